xf_test_initiator: RTL and testbench

- Self-checking initiator on the fabric req/rsp protocol, the requesting end of the interface a fabric target port serves.
- On `start`, writes `NUM` words of a deterministic pattern to consecutive addresses, then reads them back and compares.
- Counts mismatches and timeouts and reports pass/fail.
- Connects to a fabric initiator port in the cover/verif top, or directly to a target in unit benches.

---
 rtl/xf_test_initiator_if.sv | 25 ++
 rtl/xf_test_initiator.sv | 197 +++++++++++++++++++
 tb/tb_xf_test_initiator.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/xf_test_initiator_if.sv
// rtl/xf_test_initiator_if.sv - fabric req/rsp bundle between an initiator (master) and a target (slave)
interface xf_test_initiator_if #(
  parameter int AW = 24,
  parameter int DW = 32
);
  logic            req_vld;
  logic            req_gnt;
  logic            req_wr;
  logic [AW-1:0]   req_adr;
  logic [DW/8-1:0] req_strb;
  logic [DW-1:0]   req_dat;
  logic            rsp_vld;
  logic            rsp_gnt;
  logic [DW-1:0]   rsp_dat;

  modport master (
    output req_vld, req_wr, req_adr, req_strb, req_dat, rsp_gnt,
    input  req_gnt, rsp_vld, rsp_dat
  );

  modport slave (
    input  req_vld, req_wr, req_adr, req_strb, req_dat, rsp_gnt,
    output req_gnt, rsp_vld, rsp_dat
  );
endinterface

// File: rtl/xf_test_initiator.sv
// rtl/xf_test_initiator.sv - self-checking write/readback initiator with per-wait watchdog
module xf_test_initiator #(
  parameter int            AW       = 24,
  parameter int            DW       = 32,
  parameter int            NUM      = 4,
  parameter logic [AW-1:0] BASE_ADR = '0,
  parameter logic [31:0]   PATTERN  = 32'hA5A5_0000,
  parameter int            TO_CYC   = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_cnt,
  output logic       timeout,
  xf_test_initiator_if.master bus
);

  localparam int            WDW      = $clog2(TO_CYC) + 1;
  localparam logic [WDW-1:0] WDOG_LIM = WDW'(TO_CYC - 1);
  localparam logic [7:0]    LAST_IDX = 8'(NUM - 1);
  localparam logic [AW-1:0] STEP     = AW'(DW / 8);
  localparam logic [DW-1:0] PAT      = DW'(PATTERN);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR_REQ = 3'd1,
    WR_RSP = 3'd2,
    RD_REQ = 3'd3,
    RD_RSP = 3'd4,
    FIN    = 3'd5
  } state_t;

  state_t         state_q, state_d;
  logic [7:0]     idx_q, idx_d;
  logic [WDW-1:0] wdog_q, wdog_d;
  logic [7:0]     err_q, err_d;
  logic           timeout_q, timeout_d;
  logic           done_q, done_d;
  logic           busy_q, busy_d;
  logic           req_vld_q, req_vld_d;
  logic           rsp_gnt_q, rsp_gnt_d;
  logic           req_wr_q, req_wr_d;
  logic [AW-1:0]  req_adr_q, req_adr_d;
  logic [DW-1:0]  req_dat_q, req_dat_d;

  logic           active;
  logic           hs;
  logic           err_inc;
  state_t         hs_state;
  logic [7:0]     hs_idx;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wdog_d    = wdog_q;
    err_d     = err_q;
    timeout_d = timeout_q;
    active    = 1'b0;
    hs        = 1'b0;
    err_inc   = 1'b0;
    hs_state  = state_q;
    hs_idx    = idx_q;

    case (state_q)
      IDLE, FIN: begin
        if (start) begin
          state_d   = WR_REQ;
          idx_d     = 8'd0;
          err_d     = 8'd0;
          timeout_d = 1'b0;
        end
      end
      WR_REQ: begin
        active   = 1'b1;
        hs       = req_vld_q & bus.req_gnt;
        hs_state = WR_RSP;
      end
      WR_RSP: begin
        active = 1'b1;
        hs     = rsp_gnt_q & bus.rsp_vld;
        if (idx_q == LAST_IDX) begin
          hs_state = RD_REQ;
          hs_idx   = 8'd0;
        end else begin
          hs_state = WR_REQ;
          hs_idx   = idx_q + 8'd1;
        end
      end
      RD_REQ: begin
        active   = 1'b1;
        hs       = req_vld_q & bus.req_gnt;
        hs_state = RD_RSP;
      end
      RD_RSP: begin
        active = 1'b1;
        hs     = rsp_gnt_q & bus.rsp_vld;
        if (hs && (bus.rsp_dat != (PAT + DW'(idx_q)))) begin
          err_inc = 1'b1;
        end
        if (idx_q == LAST_IDX) begin
          hs_state = FIN;
        end else begin
          hs_state = RD_REQ;
          hs_idx   = idx_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A completed handshake always wins over the watchdog in the same cycle.
    if (active) begin
      if (hs) begin
        state_d = hs_state;
        idx_d   = hs_idx;
      end else if (wdog_q == WDOG_LIM) begin
        state_d   = FIN;
        timeout_d = 1'b1;
        err_inc   = 1'b1;
      end else begin
        wdog_d = wdog_q + 1'b1;
      end
    end

    if (state_d != state_q) begin
      wdog_d = '0;
    end

    if (err_inc && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

  // Bus outputs are registered off the next state so they change with it.
  always_comb begin
    req_vld_d = (state_d == WR_REQ) || (state_d == RD_REQ);
    rsp_gnt_d = (state_d == WR_RSP) || (state_d == RD_RSP);
    req_wr_d  = (state_d == WR_REQ);
    busy_d    = (state_d != IDLE) && (state_d != FIN);
    done_d    = (state_d == FIN);
    req_adr_d = req_adr_q;
    req_dat_d = req_dat_q;
    if (req_vld_d) begin
      req_adr_d = BASE_ADR + (AW'(idx_d) * STEP);
    end
    if (state_d == WR_REQ) begin
      req_dat_d = PAT + DW'(idx_d);
    end else if ((state_d == RD_REQ) || (state_d == RD_RSP)) begin
      req_dat_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= 8'd0;
      wdog_q    <= '0;
      err_q     <= 8'd0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      req_vld_q <= 1'b0;
      rsp_gnt_q <= 1'b0;
      req_wr_q  <= 1'b0;
      req_adr_q <= '0;
      req_dat_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wdog_q    <= wdog_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      req_vld_q <= req_vld_d;
      rsp_gnt_q <= rsp_gnt_d;
      req_wr_q  <= req_wr_d;
      req_adr_q <= req_adr_d;
      req_dat_q <= req_dat_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign err_cnt      = err_q;
  assign timeout      = timeout_q;
  assign pass         = done_q & (err_q == 8'd0) & ~timeout_q;
  assign bus.req_vld  = req_vld_q;
  assign bus.rsp_gnt  = rsp_gnt_q;
  assign bus.req_wr   = req_wr_q;
  assign bus.req_adr  = req_adr_q;
  assign bus.req_dat  = req_dat_q;
  assign bus.req_strb = '1;

endmodule

// File: tb/tb_xf_test_initiator.sv
// tb/tb_xf_test_initiator.sv - directed bench for xf_test_initiator with a cycle-stepped responder
module tb_xf_test_initiator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start_a, start_b;
  logic       busy_a, done_a, pass_a, to_a;
  logic       busy_b, done_b, pass_b, to_b;
  logic [7:0] err_a, err_b;

  xf_test_initiator_if #(.AW(24), .DW(32)) a ();
  xf_test_initiator_if #(.AW(8),  .DW(32)) b ();

  xf_test_initiator dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .err_cnt(err_a), .timeout(to_a), .bus(a.master)
  );

  xf_test_initiator #(.AW(8), .BASE_ADR(8'hF8)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .err_cnt(err_b), .timeout(to_b), .bus(b.master)
  );

  int total = 0;
  int bad   = 0;

  int hold_cnt    = 0;
  bit drop_rsp    = 1'b0;
  int corrupt_adr = -1;
  int stall       = 0;
  int stall_bad   = 0;

  logic [31:0] mem_a [logic [31:0]];
  logic [31:0] mem_b [logic [31:0]];
  logic [31:0] la_adr[$];
  logic [31:0] la_dat[$];
  bit          la_wr[$];
  logic [31:0] lb_adr[$];
  bit          lb_wr[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes before the edge, update responder after it.
  task automatic cyc();
    bit          acc_a, cons_a, wr_a, acc_b, cons_b, wr_b;
    logic [31:0] adr_a, adr_b;
    acc_a  = a.req_vld && a.req_gnt;
    cons_a = a.rsp_vld && a.rsp_gnt;
    wr_a   = a.req_wr;
    adr_a  = 32'(a.req_adr);
    acc_b  = b.req_vld && b.req_gnt;
    cons_b = b.rsp_vld && b.rsp_gnt;
    wr_b   = b.req_wr;
    adr_b  = 32'(b.req_adr);
    if (a.req_vld && !a.req_gnt) begin
      stall++;
      if (a.req_adr !== 24'h0 || a.req_dat !== 32'hA5A5_0000 || a.req_wr !== 1'b1) stall_bad++;
    end
    if (acc_a) begin
      la_adr.push_back(adr_a);
      la_wr.push_back(wr_a);
      la_dat.push_back(a.req_dat);
      if (wr_a) mem_a[adr_a] = a.req_dat;
    end
    if (acc_b) begin
      lb_adr.push_back(adr_b);
      lb_wr.push_back(wr_b);
      if (wr_b) mem_b[adr_b] = b.req_dat;
    end
    @(posedge clk);
    #1;
    if (cons_a) a.rsp_vld = 1'b0;
    if (acc_a && !drop_rsp) begin
      a.rsp_vld = 1'b1;
      a.rsp_dat = wr_a ? 32'h0 : ((int'(adr_a) == corrupt_adr) ? 32'hA5A5_FFFF : mem_a[adr_a]);
    end
    if (hold_cnt > 0) begin
      a.req_gnt = 1'b0;
      hold_cnt--;
    end else begin
      a.req_gnt = 1'b1;
    end
    if (cons_b) b.rsp_vld = 1'b0;
    if (acc_b) begin
      b.rsp_vld = 1'b1;
      b.rsp_dat = wr_b ? 32'h0 : mem_b[adr_b];
    end
  endtask

  task automatic go_a();
    la_adr.delete();
    la_dat.delete();
    la_wr.delete();
    start_a = 1'b1;
    cyc();
    start_a = 1'b0;
  endtask

  task automatic run_a(output int n);
    n = 0;
    while (!done_a && n < 300) begin
      cyc();
      n++;
    end
    chk("done_a_within_bound", done_a, 1'b1);
  endtask

  int n;
  logic [31:0] exp_b_adr [4];

  initial begin
    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    a.req_gnt = 1'b1; a.rsp_vld = 1'b0; a.rsp_dat = '0;
    b.req_gnt = 1'b1; b.rsp_vld = 1'b0; b.rsp_dat = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_busy", busy_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_pass", pass_a, 1'b0);
    chk("rst_err", err_a, 8'd0);
    chk("rst_timeout", to_a, 1'b0);
    chk("rst_req_vld", a.req_vld, 1'b0);
    chk("rst_rsp_gnt", a.rsp_gnt, 1'b0);
    chk("rst_req_wr", a.req_wr, 1'b0);
    chk("rst_req_adr", a.req_adr, 24'h0);
    chk("rst_req_dat", a.req_dat, 32'h0);
    chk("rst_req_strb", a.req_strb, 4'hF);

    // Clean pass with a zero-wait responder.
    go_a();
    chk("t1_first_vld", a.req_vld, 1'b1);
    chk("t1_first_wr", a.req_wr, 1'b1);
    chk("t1_first_adr", a.req_adr, 24'h0);
    chk("t1_first_dat", a.req_dat, 32'hA5A5_0000);
    chk("t1_busy", busy_a, 1'b1);
    run_a(n);
    chk("t1_cycles", n, 16);
    chk("t1_pass", pass_a, 1'b1);
    chk("t1_err", err_a, 8'd0);
    chk("t1_count", la_adr.size(), 8);
    for (int i = 0; i < 4; i++) begin
      chk("t1_wr_adr", la_adr[i], 32'(4 * i));
      chk("t1_wr_flag", la_wr[i], 1'b1);
      chk("t1_wr_dat", la_dat[i], 32'hA5A5_0000 + 32'(i));
      chk("t1_rd_adr", la_adr[4 + i], 32'(4 * i));
      chk("t1_rd_flag", la_wr[4 + i], 1'b0);
      chk("t1_rd_dat", la_dat[4 + i], 32'h0);
    end
    repeat (3) cyc();
    chk("t1_done_held", done_a, 1'b1);
    chk("t1_idle_busy", busy_a, 1'b0);

    // Corrupted read of idx 2.
    corrupt_adr = 8;
    go_a();
    run_a(n);
    chk("t2_err", err_a, 8'd1);
    chk("t2_pass", pass_a, 1'b0);
    chk("t2_done", done_a, 1'b1);
    chk("t2_count", la_adr.size(), 8);
    corrupt_adr = -1;

    // Grant withheld for 5 cycles on the first write.
    stall = 0;
    stall_bad = 0;
    hold_cnt = 5;
    go_a();
    chk("t3_err_cleared", err_a, 8'd0);
    chk("t3_done_cleared", done_a, 1'b0);
    run_a(n);
    chk("t3_stall_cycles", stall, 5);
    chk("t3_stall_stable", stall_bad, 0);
    chk("t3_count", la_adr.size(), 8);
    chk("t3_second_adr", la_adr[1], 32'h4);
    chk("t3_pass", pass_a, 1'b1);

    // Response never arrives for write 0.
    drop_rsp = 1'b1;
    go_a();
    run_a(n);
    chk("t4_cycles", n, 65);
    chk("t4_timeout", to_a, 1'b1);
    chk("t4_err", err_a, 8'd1);
    chk("t4_done", done_a, 1'b1);
    chk("t4_pass", pass_a, 1'b0);
    chk("t4_rsp_gnt", a.rsp_gnt, 1'b0);
    chk("t4_req_vld", a.req_vld, 1'b0);
    chk("t4_count", la_adr.size(), 1);
    drop_rsp = 1'b0;

    // Reset while waiting on the read response of idx 1.
    go_a();
    n = 0;
    while (la_adr.size() < 6 && n < 300) begin
      cyc();
      n++;
    end
    chk("t5_in_rd_rsp", a.rsp_gnt, 1'b1);
    chk("t5_rd1_adr", la_adr[5], 32'h4);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t5_req_vld", a.req_vld, 1'b0);
    chk("t5_rsp_gnt", a.rsp_gnt, 1'b0);
    chk("t5_busy", busy_a, 1'b0);
    chk("t5_err", err_a, 8'd0);
    cyc();
    chk("t5_still_quiet", a.req_vld, 1'b0);

    // Fresh pass with start pulses while busy.
    go_a();
    n = 0;
    while (!done_a && n < 300) begin
      start_a = (n % 3 == 1);
      cyc();
      n++;
    end
    start_a = 1'b0;
    chk("t5_restart_cycles", n, 16);
    chk("t5_restart_count", la_adr.size(), 8);
    for (int i = 0; i < 4; i++) begin
      chk("t5_wr_adr", la_adr[i], 32'(4 * i));
      chk("t5_rd_adr", la_adr[4 + i], 32'(4 * i));
    end
    chk("t5_pass", pass_a, 1'b1);

    // 8-bit address instance wraps past 0xFF.
    exp_b_adr[0] = 32'hF8;
    exp_b_adr[1] = 32'hFC;
    exp_b_adr[2] = 32'h00;
    exp_b_adr[3] = 32'h04;
    start_b = 1'b1;
    cyc();
    start_b = 1'b0;
    n = 0;
    while (!done_b && n < 300) begin
      cyc();
      n++;
    end
    chk("t6_done", done_b, 1'b1);
    chk("t6_cycles", n, 16);
    chk("t6_pass", pass_b, 1'b1);
    chk("t6_count", lb_adr.size(), 8);
    for (int i = 0; i < 4; i++) begin
      chk("t6_wr_adr", lb_adr[i], exp_b_adr[i]);
      chk("t6_rd_adr", lb_adr[4 + i], exp_b_adr[i]);
      chk("t6_rd_flag", lb_wr[4 + i], 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
